irq_controller: RTL and testbench

Interrupt controller between the switch I/O block and the CPU trap logic. Captures one-cycle interrupt strobes with a 5-bit source id (1..16), holds them in a pending bitmap, applies a software mask, and presents the highest-priority unmasked source to the CPU. A request/acknowledge/done handshake services one source at a time. A saturating counter records strobes lost because their source was already pending.

---
 rtl/irq_pkg.sv | 24 ++
 rtl/irq_prio_enc.sv | 32 +++
 rtl/irq_controller.sv | 157 +++++++++++++++
 tb/tb_irq_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared constants and FSM state encoding for the interrupt
//               controller and its priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

  // Default number of interrupt sources; ids 1..NUM_IRQ map to bits 0..NUM_IRQ-1.
  localparam int NUM_IRQ_DEFAULT = 16;

  // Width of a source id. Id 0 is reserved as "no source".
  localparam int IRQ_ID_W = 5;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio_enc
// Description : Combinational lowest-index-first priority encoder. Returns a
//               valid flag and the 1-based id (index + 1) of the lowest set
//               bit of the request vector.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEFAULT
) (
  input  logic [NUM_IRQ-1:0]  req_i,
  output logic                valid_o,
  output logic [IRQ_ID_W-1:0] id_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        id_o    = IRQ_ID_W'(i + 1);
      end
    end
  end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller
// Description : Captures one-cycle interrupt strobes into a pending bitmap,
//               applies a software mask and presents the highest-priority
//               (lowest id) unmasked source to the CPU through a
//               request / acknowledge / done handshake. Strobes that hit an
//               already-pending source are counted in a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_controller
  import irq_pkg::*;
#(
  parameter int                 NUM_IRQ    = NUM_IRQ_DEFAULT,
  parameter logic [NUM_IRQ-1:0] MASK_RESET = {NUM_IRQ{1'b1}},
  parameter int                 LOST_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                irq_in,
  input  logic [IRQ_ID_W-1:0] irq_id,
  input  logic                mask_wEn,
  input  logic [NUM_IRQ-1:0]  mask_in,
  input  logic                irq_ack,
  input  logic                irq_done,
  output logic                irq_req,
  output logic [IRQ_ID_W-1:0] irq_cause,
  output logic                in_service,
  output logic [NUM_IRQ-1:0]  pending,
  output logic [NUM_IRQ-1:0]  mask,
  output logic [LOST_W-1:0]   lost_count
);

  localparam logic [IRQ_ID_W-1:0] C_MAX_ID   = IRQ_ID_W'(NUM_IRQ);
  localparam logic [IRQ_ID_W-1:0] C_ID_ONE   = IRQ_ID_W'(1);
  localparam logic [NUM_IRQ-1:0]  C_BIT_ONE  = NUM_IRQ'(1);
  localparam logic [LOST_W-1:0]   C_LOST_MAX = {LOST_W{1'b1}};
  localparam logic [LOST_W-1:0]   C_LOST_ONE = LOST_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  irq_state_e          state_q, state_d;
  logic [IRQ_ID_W-1:0] cause_q, cause_d;
  logic                req_q;
  logic                in_service_q;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  mask_q, mask_d;
  logic [LOST_W-1:0]   lost_q, lost_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                w_strobe_valid;
  logic [IRQ_ID_W-1:0] w_set_idx;
  logic [IRQ_ID_W-1:0] w_clr_idx;
  logic [NUM_IRQ-1:0]  w_set_vec;
  logic [NUM_IRQ-1:0]  w_clr_vec;
  logic                w_ack_take;
  logic                w_lost_inc;
  logic [NUM_IRQ-1:0]  w_masked;
  logic                w_enc_valid;
  logic [IRQ_ID_W-1:0] w_enc_id;

  // Decode the incoming strobe and the ack-driven clear into one-hot vectors.
  always_comb begin
    w_strobe_valid = irq_in && (irq_id != '0) && (irq_id <= C_MAX_ID);
    w_set_idx      = irq_id - C_ID_ONE;
    w_clr_idx      = cause_q - C_ID_ONE;
    w_ack_take     = (state_q == REQUEST) && irq_ack;
    w_set_vec      = w_strobe_valid ? (C_BIT_ONE << w_set_idx) : '0;
    w_clr_vec      = w_ack_take ? (C_BIT_ONE << w_clr_idx) : '0;
    // A strobe is lost only if its bit is already pending and is not being
    // cleared this cycle; a same-cycle set/clear lets the set win instead.
    w_lost_inc     = |(pending_q & w_set_vec & ~w_clr_vec);
    // Arbitration deliberately uses the mask as it was before any write in
    // this cycle.
    w_masked       = pending_q & mask_q;
  end

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .req_i   (w_masked),
    .valid_o (w_enc_valid),
    .id_o    (w_enc_id)
  );

  // Next values for the pending bitmap, mask register and lost counter.
  always_comb begin
    pending_d = (pending_q & ~w_clr_vec) | w_set_vec;
    mask_d    = mask_wEn ? mask_in : mask_q;
    lost_d    = lost_q;
    if (w_lost_inc && (lost_q != C_LOST_MAX)) begin
      lost_d = lost_q + C_LOST_ONE;
    end
  end

  // FSM next-state: pick a source in IDLE, wait for ack, wait for done.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: begin
        if (w_enc_valid) begin
          cause_d = w_enc_id;
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        // Once raised, a request is only retired by an ack.
        if (irq_ack) begin
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        // No nesting: new requests wait until the handler finishes.
        if (irq_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state registers, with the handshake outputs registered from next-state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cause_q      <= '0;
      req_q        <= 1'b0;
      in_service_q <= 1'b0;
      pending_q    <= '0;
      mask_q       <= MASK_RESET;
      lost_q       <= '0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      req_q        <= (state_d == REQUEST);
      in_service_q <= (state_d == SERVICE);
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      lost_q       <= lost_d;
    end
  end

  assign irq_req    = req_q;
  assign irq_cause  = cause_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign mask       = mask_q;
  assign lost_count = lost_q;

endmodule : irq_controller
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_controller
// Description : Self-checking bench for irq_controller. A table of stimulus
//               records with expected post-edge outputs is applied in a loop;
//               expected values go through a scoreboard queue and are
//               compared after each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

  localparam int EXP_W = 1 + 5 + 1 + 16 + 16 + 8;

  typedef struct {
    logic        rst;
    logic        irq_in;
    logic [4:0]  id;
    logic        mwe;
    logic [15:0] mval;
    logic        ack;
    logic        done;
    int          rep;
    logic        chk_all;
    logic        req;
    logic [4:0]  cause;
    logic        insvc;
    logic [15:0] pend;
    logic [15:0] msk;
    logic [7:0]  lost;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        irq_in = 1'b0;
  logic [4:0]  irq_id = '0;
  logic        mask_wEn = 1'b0;
  logic [15:0] mask_in = '0;
  logic        irq_ack = 1'b0;
  logic        irq_done = 1'b0;
  logic        irq_req;
  logic [4:0]  irq_cause;
  logic        in_service;
  logic [15:0] pending;
  logic [15:0] mask;
  logic [7:0]  lost_count;

  int checks = 0;
  int failures = 0;

  vec_t             tbl[$];
  logic [EXP_W-1:0] sb_q[$];

  always #5 clk = ~clk;

  irq_controller #(
    .NUM_IRQ    (16),
    .MASK_RESET (16'hFFFF),
    .LOST_W     (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .irq_id     (irq_id),
    .mask_wEn   (mask_wEn),
    .mask_in    (mask_in),
    .irq_ack    (irq_ack),
    .irq_done   (irq_done),
    .irq_req    (irq_req),
    .irq_cause  (irq_cause),
    .in_service (in_service),
    .pending    (pending),
    .mask       (mask),
    .lost_count (lost_count)
  );

  function automatic vec_t mk(
    input logic rst, input logic in, input logic [4:0] id,
    input logic mwe, input logic [15:0] mval,
    input logic ack, input logic done, input int rep, input logic chk_all,
    input logic req, input logic [4:0] cause, input logic insvc,
    input logic [15:0] pend, input logic [15:0] msk, input logic [7:0] lost);
    vec_t v;
    v.rst = rst; v.irq_in = in; v.id = id; v.mwe = mwe; v.mval = mval;
    v.ack = ack; v.done = done; v.rep = rep; v.chk_all = chk_all;
    v.req = req; v.cause = cause; v.insvc = insvc;
    v.pend = pend; v.msk = msk; v.lost = lost;
    return v;
  endfunction

  // Drive one cycle of stimulus, push its expectation, then compare after the edge.
  task automatic step(input vec_t v, input bit do_chk, input string name);
    logic [EXP_W-1:0] exp_v;
    logic [EXP_W-1:0] act_v;
    reset    = v.rst;
    irq_in   = v.irq_in;
    irq_id   = v.id;
    mask_wEn = v.mwe;
    mask_in  = v.mval;
    irq_ack  = v.ack;
    irq_done = v.done;
    sb_q.push_back({v.req, v.cause, v.insvc, v.pend, v.msk, v.lost});
    @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    act_v = {irq_req, irq_cause, in_service, pending, mask, lost_count};
    if (do_chk) begin
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL %s: actual req=%b cause=%0d insvc=%b pend=%h mask=%h lost=%0d required req=%b cause=%0d insvc=%b pend=%h mask=%h lost=%0d",
                 name, act_v[46], act_v[45:41], act_v[40], act_v[39:24], act_v[23:8], act_v[7:0],
                 exp_v[46], exp_v[45:41], exp_v[40], exp_v[39:24], exp_v[23:8], exp_v[7:0]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         rst in id   mwe mval     ack dn rep all  req cause ins pend      mask      lost
    // Reset, single source, done ignored in REQUEST, priority while in SERVICE
    tbl.push_back(mk(1, 0, 0,  0, 16'h0000, 0, 0, 1,  1,  0, 0, 0, 16'h0000, 16'hFFFF, 0));
    tbl.push_back(mk(0, 1, 3,  0, 16'h0000, 0, 0, 1,  1,  0, 0, 0, 16'h0004, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 0, 0, 1,  1,  1, 3, 0, 16'h0004, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 0, 1, 1,  1,  1, 3, 0, 16'h0004, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 0, 1,  1,  0, 3, 1, 16'h0000, 16'hFFFF, 0));
    tbl.push_back(mk(0, 1, 9,  0, 16'h0000, 1, 0, 1,  1,  0, 3, 1, 16'h0100, 16'hFFFF, 0));
    tbl.push_back(mk(0, 1, 2,  0, 16'h0000, 0, 0, 1,  1,  0, 3, 1, 16'h0102, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 0, 1, 1,  1,  0, 3, 0, 16'h0102, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 0, 0, 1,  1,  1, 2, 0, 16'h0102, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 0, 1,  1,  0, 2, 1, 16'h0100, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 0, 1, 1,  1,  0, 2, 0, 16'h0100, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 0, 0, 1,  1,  1, 9, 0, 16'h0100, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 0, 1,  1,  0, 9, 1, 16'h0000, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 0, 1, 1,  1,  0, 9, 0, 16'h0000, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 0, 1,  1,  0, 9, 0, 16'h0000, 16'hFFFF, 0));
    // Masking: masked source stays pending without a request
    tbl.push_back(mk(0, 0, 0,  1, 16'hFFFE, 0, 0, 1,  1,  0, 9, 0, 16'h0000, 16'hFFFE, 0));
    tbl.push_back(mk(0, 1, 1,  0, 16'h0000, 0, 0, 1,  1,  0, 9, 0, 16'h0001, 16'hFFFE, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 0, 0, 20, 1,  0, 9, 0, 16'h0001, 16'hFFFE, 0));
    tbl.push_back(mk(0, 0, 0,  1, 16'hFFFF, 0, 0, 1,  1,  0, 9, 0, 16'h0001, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 0, 0, 1,  1,  1, 1, 0, 16'h0001, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 0, 1,  1,  0, 1, 1, 16'h0000, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 0, 1, 1,  1,  0, 1, 0, 16'h0000, 16'hFFFF, 0));
    // Committed request survives a mask write; ack/strobe collision on id 4
    tbl.push_back(mk(0, 1, 4,  0, 16'h0000, 0, 0, 1,  1,  0, 1, 0, 16'h0008, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 0, 0, 1,  1,  1, 4, 0, 16'h0008, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  1, 16'h0000, 0, 0, 1,  1,  1, 4, 0, 16'h0008, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 4,  0, 16'h0000, 1, 0, 1,  1,  0, 4, 1, 16'h0008, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 0,  1, 16'hFFFF, 0, 1, 1,  1,  0, 4, 0, 16'h0008, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 0, 0, 1,  1,  1, 4, 0, 16'h0008, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 0, 1,  1,  0, 4, 1, 16'h0000, 16'hFFFF, 0));
    tbl.push_back(mk(0, 0, 0,  1, 16'h0000, 0, 1, 1,  1,  0, 4, 0, 16'h0000, 16'h0000, 0));
    // Lost strobes and saturation with everything masked
    tbl.push_back(mk(0, 1, 5,  0, 16'h0000, 0, 0, 1,  1,  0, 4, 0, 16'h0010, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 5,  0, 16'h0000, 0, 0, 1,  1,  0, 4, 0, 16'h0010, 16'h0000, 1));
    tbl.push_back(mk(0, 1, 5,  0, 16'h0000, 0, 0, 1,  1,  0, 4, 0, 16'h0010, 16'h0000, 2));
    tbl.push_back(mk(0, 1, 5,  0, 16'h0000, 0, 0, 252,0,  0, 4, 0, 16'h0010, 16'h0000, 254));
    tbl.push_back(mk(0, 1, 5,  0, 16'h0000, 0, 0, 1,  1,  0, 4, 0, 16'h0010, 16'h0000, 255));
    tbl.push_back(mk(0, 1, 5,  0, 16'h0000, 0, 0, 47, 1,  0, 4, 0, 16'h0010, 16'h0000, 255));
    tbl.push_back(mk(0, 1, 0,  0, 16'h0000, 0, 0, 1,  1,  0, 4, 0, 16'h0010, 16'h0000, 255));
    tbl.push_back(mk(0, 1, 17, 0, 16'h0000, 0, 0, 1,  1,  0, 4, 0, 16'h0010, 16'h0000, 255));
    tbl.push_back(mk(0, 1, 31, 0, 16'h0000, 0, 0, 1,  1,  0, 4, 0, 16'h0010, 16'h0000, 255));
    tbl.push_back(mk(0, 0, 5,  0, 16'h0000, 0, 0, 1,  1,  0, 4, 0, 16'h0010, 16'h0000, 255));

    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        step(tbl[i], tbl[i].chk_all || (r == tbl[i].rep - 1), $sformatf("vec%0d.%0d", i, r));
      end
    end

    // Reset while a request is outstanding: unmask id 5, let it request, then
    // reset together with a strobe, an ack and a mask write, all of which lose.
    step(mk(0, 0, 0, 1, 16'hFFFF, 0, 0, 1, 1, 0, 4, 0, 16'h0010, 16'hFFFF, 255), 1'b1, "rst_unmask");
    step(mk(0, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 1, 5, 0, 16'h0010, 16'hFFFF, 255), 1'b1, "rst_req_up");
    step(mk(1, 1, 7, 1, 16'h0000, 1, 0, 1, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 0),   1'b1, "rst_mid_req");
    step(mk(0, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 0),   1'b1, "rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_irq_controller
`default_nettype wire
